// File: rtl/viterbi_seq.sv
// Frame sequencer for the rate-1/2 Viterbi decoder: registers received pairs onto the
// branch-metric bus, strobes ACS/survivor writes per symbol and launches traceback per frame.
module viterbi_seq #(
    parameter int ADDR_W = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_pair,
    output logic [1:0]        bmc_pair,
    output logic              acs_en,
    output logic              acs_init,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              tb_start,
    output logic [ADDR_W-1:0] tb_addr,
    input  logic              tb_done,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        LAUNCH,
        WAIT_TB
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] sym_cnt;
    logic              accept;
    logic              last_sym;
    logic              tb_finish;

    assign accept    = in_valid & in_ready;
    assign last_sym  = (sym_cnt == '1);
    assign tb_finish = (state == WAIT_TB) & tb_done;
    assign tb_addr   = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = last_sym ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && last_sym) begin
                    next_state = DRAIN;
                end
            end
            DRAIN:   next_state = LAUNCH;
            LAUNCH:  next_state = WAIT_TB;
            WAIT_TB: begin
                if (tb_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            RUN:     in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Strobes trail the accepting edge by one cycle; tb_start is launched from DRAIN so it
    // is high exactly during LAUNCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt   <= '0;
            frame_cnt <= '0;
            bmc_pair  <= '0;
            acs_en    <= 1'b0;
            acs_init  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            tb_start  <= 1'b0;
        end else begin
            acs_en   <= accept;
            wr_en    <= accept;
            acs_init <= accept && (sym_cnt == '0);
            tb_start <= (state == DRAIN);
            if (accept) begin
                bmc_pair <= in_pair;
                wr_addr  <= sym_cnt;
                sym_cnt  <= sym_cnt + ADDR_W'(1);
            end
            if (tb_finish) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
                sym_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_seq.sv
// Scoreboard bench for viterbi_seq with a 4-symbol frame and a 2-bit frame counter.
module tb_viterbi_seq;

    localparam int ADDR_W = 2;
    localparam int FCNT_W = 2;
    localparam int N      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [1:0]        in_pair = 2'b00;
    logic              tb_done = 1'b0;
    logic              in_ready;
    logic [1:0]        bmc_pair;
    logic              acs_en;
    logic              acs_init;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              tb_start;
    logic [ADDR_W-1:0] tb_addr;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    viterbi_seq #(.ADDR_W(ADDR_W), .FCNT_W(FCNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pair   (in_pair),
        .bmc_pair  (bmc_pair),
        .acs_en    (acs_en),
        .acs_init  (acs_init),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .tb_start  (tb_start),
        .tb_addr   (tb_addr),
        .tb_done   (tb_done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        pair;
        logic [ADDR_W-1:0] addr;
        logic              init;
    } exp_t;

    exp_t              sb[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_strobes = 0;
    int                n_tb_start = 0;
    int                sym_idx = 0;
    logic [FCNT_W-1:0] exp_frame = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (tb_start === 1'b1) n_tb_start++;
        if (acs_en === 1'b1 || wr_en === 1'b1) begin
            n_strobes++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("acs_en", acs_en, 1);
                check("wr_en", wr_en, 1);
                check("bmc_pair", bmc_pair, e.pair);
                check("wr_addr", wr_addr, e.addr);
                check("acs_init", acs_init, e.init);
            end
        end else if (acs_init !== 1'b0) begin
            check("stray_acs_init", acs_init, 0);
        end
    end

    task automatic send(input logic [1:0] p);
        exp_t e;
        in_valid = 1'b1;
        in_pair  = p;
        @(negedge clk);
        check("send_ready", in_ready, 1);
        e.pair = p;
        e.addr = ADDR_W'(sym_idx);
        e.init = (sym_idx == 0);
        sb.push_back(e);
        sym_idx = (sym_idx + 1) % N;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("acs_latency", acs_en, 1);
        check("wr_latency", wr_en, 1);
    endtask

    // mode: 0 = tb_done only in WAIT_TB, 1 = stray pulse during LAUNCH, 2 = held from LAUNCH
    task automatic run_frame(input logic [7:0] pairs, input int g1, input int g2, input int g3,
                             input bit gap_done, input bit hold_valid, input int mode,
                             input int tb_delay);
        int gaps[3];
        gaps[0] = g1;
        gaps[1] = g2;
        gaps[2] = g3;
        for (int i = 0; i < N; i++) begin
            send(pairs[2*i +: 2]);
            if (i < N - 1) begin
                for (int k = 0; k < gaps[i]; k++) begin
                    if (gap_done) tb_done = 1'b1;
                    @(negedge clk);
                    check("gap_ready", in_ready, 1);
                    check("gap_busy", busy, 1);
                    @(posedge clk);
                    #1;
                    tb_done = 1'b0;
                end
            end
        end
        if (hold_valid) begin
            in_valid = 1'b1;
            in_pair  = 2'b10;
        end
        @(negedge clk);
        check("drain_ready", in_ready, 0);
        check("drain_busy", busy, 1);
        check("drain_tb_start", tb_start, 0);
        @(negedge clk);
        check("launch_tb_start", tb_start, 1);
        check("tb_addr", tb_addr, 2'b11);
        check("launch_ready", in_ready, 0);
        if (mode != 0) tb_done = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) tb_done = 1'b0;
        for (int k = 0; k < tb_delay; k++) begin
            @(negedge clk);
            check("wait_ready", in_ready, 0);
            check("wait_busy", busy, 1);
            check("wait_tb_start", tb_start, 0);
            check("wait_frame_cnt", frame_cnt, exp_frame);
        end
        tb_done = 1'b1;
        @(posedge clk);
        #1;
        tb_done   = 1'b0;
        exp_frame = exp_frame + FCNT_W'(1);
        sym_idx   = 0;
        check("frame_cnt", frame_cnt, exp_frame);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_acs_en", acs_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_tb_start", tb_start, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_bmc_pair", bmc_pair, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;

        tb_done = 1'b1;
        @(posedge clk);
        #1;
        tb_done = 1'b0;
        check("idle_done_busy", busy, 0);
        check("idle_done_fcnt", frame_cnt, 0);

        run_frame({2'b11, 2'b10, 2'b01, 2'b00}, 0, 0, 0, 1'b0, 1'b1, 0, 5);
        run_frame({2'b00, 2'b11, 2'b01, 2'b10}, 0, 2, 3, 1'b1, 1'b0, 1, 3);
        run_frame(8'($urandom), 1, 0, 1, 1'b0, 1'b0, 2, 1);
        run_frame(8'($urandom), 0, 0, 0, 1'b0, 1'b1, 0, 2);
        run_frame(8'($urandom), 0, 1, 0, 1'b0, 1'b0, 0, 1);

        send(2'b01);
        send(2'b10);
        in_valid = 1'b1;
        in_pair  = 2'b11;
        rst      = 1'b1;
        tb_done  = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tb_done  = 1'b0;
        sym_idx  = 0;
        exp_frame = '0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_acs_en", acs_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_bmc_pair", bmc_pair, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_no_tb_start", tb_start, 0);
        end
        @(posedge clk);
        #1;

        run_frame({2'b10, 2'b01, 2'b11, 2'b01}, 0, 0, 0, 1'b0, 1'b0, 0, 2);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("strobe_total", n_strobes, 26);
        check("tb_start_total", n_tb_start, 6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
